hazard_ctrl: RTL and testbench

Pipeline stall and MDU-occupancy controller for the five-stage MIPS core. It sits beside the F/D and D/E pipeline registers. It decides from Tuse/Tnew comparisons and multiply/divide occupancy whether the instruction in D must be held, and drives the PC enable, F/D enable and D/E flush. It also owns the mult/div busy countdown and a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_ctrl.sv | 86 ++++++++
 tb/tb_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// ==========================================================================
// hazard_ctrl_if : hazard-check inputs and stall-control outputs of hazard_ctrl
// Revision 1.0
// ==========================================================================
`default_nettype none

interface hazard_ctrl_if;
  logic [4:0]  D_rs_addr;
  logic [4:0]  D_rt_addr;
  logic [1:0]  D_rs_tuse;
  logic [1:0]  D_rt_tuse;
  logic        D_md_op;
  logic [4:0]  E_wa;
  logic [1:0]  E_tnew;
  logic [4:0]  M_wa;
  logic [1:0]  M_tnew;
  logic        E_md_start;
  logic        E_md_div;
  logic        pc_en;
  logic        fd_en;
  logic        de_flush;
  logic        stall;
  logic        md_busy;
  logic [31:0] stall_cnt;

  // Pipeline side drives the decode/execute/memory state, controller answers.
  modport master (
    output D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_md_op,
    output E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
    input  pc_en, fd_en, de_flush, stall, md_busy, stall_cnt
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_md_op,
    input  E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
    output pc_en, fd_en, de_flush, stall, md_busy, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ==========================================================================
// hazard_ctrl : Tuse/Tnew stall decision, MDU busy countdown, stall counter
// Revision 1.0
// ==========================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [3:0] C_MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] C_DIV_LD  = 4'(DIV_CYC);

  logic [3:0]  md_cnt_q;
  logic [3:0]  md_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic        rs_haz;
  logic        rt_haz;
  logic        md_haz;
  logic        md_busy;
  logic        stall;

  // A source is hazardous when a producer in E or M will not have its result
  // ready by the time D needs it; $0 and unread operands never conflict.
  function automatic logic src_hazard(
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    return (tuse != 2'd3) && (addr != 5'd0) &&
           (((e_wa == addr) && (e_tnew > tuse)) ||
            ((m_wa == addr) && (m_tnew > tuse)));
  endfunction

  always_comb begin
    rs_haz  = src_hazard(hz.D_rs_addr, hz.D_rs_tuse, hz.E_wa, hz.E_tnew,
                         hz.M_wa, hz.M_tnew);
    rt_haz  = src_hazard(hz.D_rt_addr, hz.D_rt_tuse, hz.E_wa, hz.E_tnew,
                         hz.M_wa, hz.M_tnew);
    md_busy = (md_cnt_q != 4'd0);
    md_haz  = hz.D_md_op && (hz.E_md_start || md_busy);
    stall   = rs_haz || rt_haz || md_haz;

    // A new start always reloads, even over a running count.
    md_cnt_d = md_cnt_q;
    if (hz.E_md_start) begin
      md_cnt_d = hz.E_md_div ? C_DIV_LD : C_MULT_LD;
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall     = stall;
  assign hz.pc_en     = ~stall;
  assign hz.fd_en     = ~stall;
  assign hz.de_flush  = stall;
  assign hz.md_busy   = md_busy;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ==========================================================================
// tb_hazard_ctrl : directed and randomized checks of hazard_ctrl vs a model
// Revision 1.0
// ==========================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  // Reference model state: cycle index, latest MDU start, expected counter.
  int          cyc;
  bit          start_vld;
  int          start_cyc;
  int          start_len;
  logic [31:0] exp_cnt;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_busy();
    return start_vld && (cyc > start_cyc) && (cyc <= start_cyc + start_len);
  endfunction

  function automatic bit src_conflict(input int addr, input int tuse);
    if (tuse == 3 || addr == 0) return 1'b0;
    if (int'(hz.E_wa) == addr && int'(hz.E_tnew) > tuse) return 1'b1;
    if (int'(hz.M_wa) == addr && int'(hz.M_tnew) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    bit md;
    md = hz.D_md_op && (hz.E_md_start || model_busy());
    return src_conflict(int'(hz.D_rs_addr), int'(hz.D_rs_tuse)) ||
           src_conflict(int'(hz.D_rt_addr), int'(hz.D_rt_tuse)) || md;
  endfunction

  task automatic tick();
    if (model_stall() && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    if (hz.E_md_start) begin
      start_vld = 1'b1;
      start_cyc = cyc;
      start_len = hz.E_md_div ? 10 : 5;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    hz.D_rs_addr  = 5'd0;
    hz.D_rt_addr  = 5'd0;
    hz.D_rs_tuse  = 2'd3;
    hz.D_rt_tuse  = 2'd3;
    hz.D_md_op    = 1'b0;
    hz.E_wa       = 5'd0;
    hz.E_tnew     = 2'd0;
    hz.M_wa       = 5'd0;
    hz.M_tnew     = 2'd0;
    hz.E_md_start = 1'b0;
    hz.E_md_div   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    cyc = 0; start_vld = 1'b0; start_cyc = 0; start_len = 0; exp_cnt = 32'd0;
    @(posedge clk);
    #1;
    total++;
    if ({hz.stall, hz.pc_en, hz.fd_en, hz.de_flush, hz.md_busy} !== 5'b01100) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=01100",
               {hz.stall, hz.pc_en, hz.fd_en, hz.de_flush, hz.md_busy});
    end
    total++;
    if (hz.stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%h want=0", hz.stall_cnt);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] base;
    idle();
    base = exp_cnt;
    hz.D_rs_addr = 5'd5; hz.D_rs_tuse = 2'd0; hz.E_wa = 5'd5; hz.E_tnew = 2'd2;
    #1;
    total++;
    if ({hz.stall, hz.pc_en, hz.fd_en, hz.de_flush} !== 4'b1001) begin
      bad++;
      $display("FAIL load_use_e got=%b want=1001",
               {hz.stall, hz.pc_en, hz.fd_en, hz.de_flush});
    end
    tick();
    hz.E_wa = 5'd0; hz.E_tnew = 2'd0; hz.M_wa = 5'd5; hz.M_tnew = 2'd1;
    #1;
    total++;
    if (hz.stall !== 1'b1) begin
      bad++;
      $display("FAIL load_use_m got=%b want=1", hz.stall);
    end
    tick();
    hz.M_wa = 5'd0; hz.M_tnew = 2'd0;
    #1;
    total++;
    if (hz.stall !== 1'b0) begin
      bad++;
      $display("FAIL load_use_clear got=%b want=0", hz.stall);
    end
    total++;
    if (hz.stall_cnt !== base + 32'd2) begin
      bad++;
      $display("FAIL load_use_cnt got=%h want=%h", hz.stall_cnt, base + 32'd2);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    idle();
    hz.D_rs_addr = 5'd0; hz.D_rs_tuse = 2'd0; hz.E_wa = 5'd0; hz.E_tnew = 2'd2;
    #1;
    total++;
    if (hz.stall !== 1'b0) begin
      bad++;
      $display("FAIL zero_reg got=%b want=0", hz.stall);
    end
    tick();
    idle();
    hz.D_rt_addr = 5'd7; hz.D_rt_tuse = 2'd3; hz.E_wa = 5'd7; hz.E_tnew = 2'd2;
    #1;
    total++;
    if (hz.stall !== 1'b0) begin
      bad++;
      $display("FAIL rt_unread got=%b want=0", hz.stall);
    end
    tick();
    hz.D_rt_tuse = 2'd1;
    #1;
    total++;
    if (hz.stall !== 1'b1) begin
      bad++;
      $display("FAIL rt_read got=%b want=1", hz.stall);
    end
    tick();
    idle();
  endtask

  task automatic test_mult();
    idle();
    for (int c = 0; c < 8; c++) begin
      hz.D_md_op = 1'b1; hz.E_md_start = (c == 0); hz.E_md_div = 1'b0;
      #1;
      total++;
      if ({hz.stall, hz.md_busy} !== {1'(c <= 5), 1'(c >= 1 && c <= 5)}) begin
        bad++;
        $display("FAIL mult_c%0d got stall/busy=%b%b want=%b%b", c, hz.stall,
                 hz.md_busy, 1'(c <= 5), 1'(c >= 1 && c <= 5));
      end
      tick();
    end
    idle();
  endtask

  task automatic test_div();
    int nbusy;
    idle();
    nbusy = 0;
    for (int c = 0; c < 13; c++) begin
      hz.E_md_start = (c == 0); hz.E_md_div = 1'b1;
      hz.D_rs_addr = 5'd9; hz.D_rs_tuse = 2'd1;
      #1;
      if (hz.md_busy === 1'b1) nbusy++;
      total++;
      if ({hz.stall, hz.md_busy} !== {1'b0, 1'(c >= 1 && c <= 10)}) begin
        bad++;
        $display("FAIL div_c%0d got stall/busy=%b%b want=0%b", c, hz.stall,
                 hz.md_busy, 1'(c >= 1 && c <= 10));
      end
      tick();
    end
    total++;
    if (nbusy != 10) begin
      bad++;
      $display("FAIL div_len got=%0d want=10", nbusy);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    hz.E_md_start = 1'b1; hz.E_md_div = 1'b1;
    tick();
    hz.E_md_start = 1'b0;
    tick();
    tick();
    total++;
    if (hz.md_busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre got=%b want=1", hz.md_busy);
    end
    reset = 1'b0;
    #1;
    start_vld = 1'b0;
    exp_cnt = 32'd0;
    total++;
    if ({hz.md_busy, hz.stall_cnt} !== {1'b0, 32'd0}) begin
      bad++;
      $display("FAIL rst_mid_async got busy=%b cnt=%h want busy=0 cnt=0",
               hz.md_busy, hz.stall_cnt);
    end
    reset = 1'b1;
    hz.D_md_op = 1'b1;
    #1;
    total++;
    if (hz.stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_after got=%b want=0", hz.stall);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    bit s;
    for (int i = 0; i < 400; i++) begin
      hz.D_rs_addr  = 5'($urandom_range(0, 3));
      hz.D_rt_addr  = 5'($urandom_range(0, 3));
      hz.D_rs_tuse  = 2'($urandom_range(0, 3));
      hz.D_rt_tuse  = 2'($urandom_range(0, 3));
      hz.E_wa       = 5'($urandom_range(0, 3));
      hz.E_tnew     = 2'($urandom_range(0, 3));
      hz.M_wa       = 5'($urandom_range(0, 3));
      hz.M_tnew     = 2'($urandom_range(0, 3));
      hz.D_md_op    = ($urandom_range(0, 3) == 0);
      hz.E_md_start = ($urandom_range(0, 7) == 0);
      hz.E_md_div   = 1'($urandom_range(0, 1));
      #1;
      s = model_stall();
      total++;
      if ({hz.stall, hz.pc_en, hz.fd_en, hz.de_flush, hz.md_busy} !==
          {s, ~s, ~s, s, model_busy()}) begin
        bad++;
        $display("FAIL rand_ctrl i=%0d got=%b want=%b", i,
                 {hz.stall, hz.pc_en, hz.fd_en, hz.de_flush, hz.md_busy},
                 {s, ~s, ~s, s, model_busy()});
      end
      total++;
      if (hz.stall_cnt !== exp_cnt) begin
        bad++;
        $display("FAIL rand_cnt i=%0d got=%h want=%h", i, hz.stall_cnt, exp_cnt);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_saturation();
    idle();
    hz.D_rs_addr = 5'd5; hz.D_rs_tuse = 2'd0; hz.E_wa = 5'd5; hz.E_tnew = 2'd2;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    tick();
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    tick();
    total++;
    if (hz.stall_cnt !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL sat_reach got=%h want=ffffffff", hz.stall_cnt);
    end
    tick();
    tick();
    total++;
    if ({hz.stall, hz.stall_cnt} !== {1'b1, 32'hFFFF_FFFF}) begin
      bad++;
      $display("FAIL sat_hold got stall=%b cnt=%h want stall=1 cnt=ffffffff",
               hz.stall, hz.stall_cnt);
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mult();
    test_div();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
